// File: rtl/rs_age_dual_issue_if.sv
// Dispatch, wakeup and CDB result bundle of the rs_age_dual_issue reservation station.
// The master drives dispatch and wakeup; the slave (the station) drives ready, results and counters.
interface rs_age_dual_issue_if #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int INS_W = 6,
  parameter int NWAKE = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                   rdy;
  logic                   jp_wrong;
  logic                   in_valid;
  logic                   in_ready;
  logic [INS_W-1:0]       insty;
  logic                   rs1_ready;
  logic                   rs2_ready;
  logic [XLEN-1:0]        reg1;
  logic [XLEN-1:0]        reg2;
  logic [XLEN-1:0]        imm;
  logic [ROB_W-1:0]       rob_idx;
  logic [NWAKE-1:0]       wk_valid;
  logic [NWAKE*ROB_W-1:0] wk_idx;
  logic [NWAKE*XLEN-1:0]  wk_val;
  logic                   ari_valid;
  logic [ROB_W-1:0]       ari_idx;
  logic [XLEN-1:0]        ari_val;
  logic                   cmp_valid;
  logic [ROB_W-1:0]       cmp_idx;
  logic [XLEN-1:0]        cmp_val;
  logic [OCC_W-1:0]       occupancy;
  logic [31:0]            perf_issue;
  logic [31:0]            perf_stall;

  modport master (
    output rdy, jp_wrong, in_valid, insty, rs1_ready, rs2_ready, reg1, reg2, imm, rob_idx,
           wk_valid, wk_idx, wk_val,
    input  in_ready, ari_valid, ari_idx, ari_val, cmp_valid, cmp_idx, cmp_val,
           occupancy, perf_issue, perf_stall
  );

  modport slave (
    input  rdy, jp_wrong, in_valid, insty, rs1_ready, rs2_ready, reg1, reg2, imm, rob_idx,
           wk_valid, wk_idx, wk_val,
    output in_ready, ari_valid, ari_idx, ari_val, cmp_valid, cmp_idx, cmp_val,
           occupancy, perf_issue, perf_stall
  );
endinterface

// File: rtl/rs_age_dual_issue.sv
// Unified age-ordered reservation station with an integer ALU; issues the oldest ready op per lane.
// Optional feature macro: RS_PERF_EN adds issue/stall performance counters (tied to 0 otherwise).
module rs_age_dual_issue #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int INS_W = 6,
  parameter int NWAKE = 2
) (
  input  logic                clk,
  input  logic                rst,
  rs_age_dual_issue_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Register-register ops are odd, immediate forms even; SUB is the one even register op.
  localparam logic [INS_W-1:0] OP_ADDI  = INS_W'(0);
  localparam logic [INS_W-1:0] OP_ADD   = INS_W'(1);
  localparam logic [INS_W-1:0] OP_SUB   = INS_W'(2);
  localparam logic [INS_W-1:0] OP_XORI  = INS_W'(4);
  localparam logic [INS_W-1:0] OP_XOR   = INS_W'(5);
  localparam logic [INS_W-1:0] OP_ORI   = INS_W'(6);
  localparam logic [INS_W-1:0] OP_OR    = INS_W'(7);
  localparam logic [INS_W-1:0] OP_ANDI  = INS_W'(8);
  localparam logic [INS_W-1:0] OP_AND   = INS_W'(9);
  localparam logic [INS_W-1:0] OP_SLLI  = INS_W'(10);
  localparam logic [INS_W-1:0] OP_SLL   = INS_W'(11);
  localparam logic [INS_W-1:0] OP_SRLI  = INS_W'(12);
  localparam logic [INS_W-1:0] OP_SRL   = INS_W'(13);
  localparam logic [INS_W-1:0] OP_SRAI  = INS_W'(14);
  localparam logic [INS_W-1:0] OP_SRA   = INS_W'(15);
  localparam logic [INS_W-1:0] OP_SLTI  = INS_W'(16);
  localparam logic [INS_W-1:0] OP_SLT   = INS_W'(17);
  localparam logic [INS_W-1:0] OP_SLTIU = INS_W'(18);
  localparam logic [INS_W-1:0] OP_SLTU  = INS_W'(19);
  localparam logic [INS_W-1:0] OP_BEQ   = INS_W'(32);
  localparam logic [INS_W-1:0] OP_BNE   = INS_W'(33);
  localparam logic [INS_W-1:0] OP_BLT   = INS_W'(34);
  localparam logic [INS_W-1:0] OP_BGE   = INS_W'(35);
  localparam logic [INS_W-1:0] OP_BLTU  = INS_W'(36);
  localparam logic [INS_W-1:0] OP_BGEU  = INS_W'(37);
  localparam logic [INS_W-1:0] OP_JALR  = INS_W'(38);

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] val;
  } wake_t;

  function automatic wake_t wake_lookup(input logic [ROB_W-1:0]       tag,
                                        input logic [NWAKE-1:0]       wv,
                                        input logic [NWAKE*ROB_W-1:0] wi,
                                        input logic [NWAKE*XLEN-1:0]  wd);
    wake_t w;
    w = '0;
    for (int k = NWAKE - 1; k >= 0; k--) begin
      if (wv[k] && wi[k*ROB_W +: ROB_W] == tag) begin
        w.hit = 1'b1;
        w.val = wd[k*XLEN +: XLEN];
      end
    end
    return w;
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [INS_W-1:0] op,
                                          input logic [XLEN-1:0]  a,
                                          input logic [XLEN-1:0]  b);
    logic [XLEN-1:0] r;
    logic [4:0]      sh;
    sh = b[4:0];
    case (op)
      OP_ADD,  OP_ADDI:  r = a + b;
      OP_SUB:            r = a - b;
      OP_XOR,  OP_XORI:  r = a ^ b;
      OP_OR,   OP_ORI:   r = a | b;
      OP_AND,  OP_ANDI:  r = a & b;
      OP_SLL,  OP_SLLI:  r = a << sh;
      OP_SRL,  OP_SRLI:  r = a >> sh;
      OP_SRA,  OP_SRAI:  r = $unsigned($signed(a) >>> sh);
      OP_SLT,  OP_SLTI:  r = XLEN'($signed(a) < $signed(b));
      OP_SLTU, OP_SLTIU: r = XLEN'(a < b);
      OP_BEQ:            r = XLEN'(a == b);
      OP_BNE:            r = XLEN'(a != b);
      OP_BLT:            r = XLEN'($signed(a) < $signed(b));
      OP_BGE:            r = XLEN'($signed(a) >= $signed(b));
      OP_BLTU:           r = XLEN'(a < b);
      OP_BGEU:           r = XLEN'(a >= b);
      OP_JALR:           r = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
      default:           r = '0;
    endcase
    return r;
  endfunction

  logic [DEPTH-1:0] valid, r1ok, r2ok;
  logic [INS_W-1:0] op    [DEPTH];
  logic [XLEN-1:0]  v1    [DEPTH];
  logic [XLEN-1:0]  v2    [DEPTH];
  logic [ROB_W-1:0] rob   [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];

  wake_t            wk1 [DEPTH];
  wake_t            wk2 [DEPTH];
  logic [DEPTH-1:0] cand_a, cand_c, sel_a, sel_c, issue;
  logic             any_a, any_c;
  logic [INS_W-1:0] a_op, c_op;
  logic [XLEN-1:0]  a_v1, a_v2, c_v1, c_v2;
  logic [ROB_W-1:0] a_rob, c_rob;

  logic             in_ready, do_disp, d_use_imm;
  logic [IDX_W-1:0] alloc;
  wake_t            d_wk1, d_wk2;
  logic             d_r1ok, d_r2ok;
  logic [XLEN-1:0]  d_v1, d_v2;

  logic             ari_valid_q, cmp_valid_q;
  logic [ROB_W-1:0] ari_idx_q, cmp_idx_q;
  logic [XLEN-1:0]  ari_val_q, cmp_val_q;

  // Wakeup values bypass into select so an op issues in the same cycle its last operand arrives.
  always_comb begin
    cand_a = '0;
    cand_c = '0;
    sel_a  = '0;
    sel_c  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = wake_lookup(v1[i][ROB_W-1:0], bus.wk_valid, bus.wk_idx, bus.wk_val);
      wk2[i] = wake_lookup(v2[i][ROB_W-1:0], bus.wk_valid, bus.wk_idx, bus.wk_val);
      if (valid[i] && (r1ok[i] || wk1[i].hit) && (r2ok[i] || wk2[i].hit)) begin
        cand_a[i] = ~op[i][5];
        cand_c[i] =  op[i][5];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel_a[i] = cand_a[i] & ~|(older[i] & cand_a);
      sel_c[i] = cand_c[i] & ~|(older[i] & cand_c);
    end
    issue = sel_a | sel_c;
    any_a = |sel_a;
    any_c = |sel_c;
    a_op = '0; a_v1 = '0; a_v2 = '0; a_rob = '0;
    c_op = '0; c_v1 = '0; c_v2 = '0; c_rob = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_a[i]) begin
        a_op  = op[i];
        a_rob = rob[i];
        a_v1  = r1ok[i] ? v1[i] : wk1[i].val;
        a_v2  = r2ok[i] ? v2[i] : wk2[i].val;
      end
      if (sel_c[i]) begin
        c_op  = op[i];
        c_rob = rob[i];
        c_v1  = r1ok[i] ? v1[i] : wk1[i].val;
        c_v2  = r2ok[i] ? v2[i] : wk2[i].val;
      end
    end
  end

  always_comb begin
    in_ready  = ~&valid;
    do_disp   = bus.in_valid & in_ready;
    alloc     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) alloc = IDX_W'(i);
    end
    d_use_imm = (bus.insty == OP_JALR) ||
                (!bus.insty[5] && !bus.insty[0] && bus.insty != OP_SUB);
    d_wk1     = wake_lookup(bus.reg1[ROB_W-1:0], bus.wk_valid, bus.wk_idx, bus.wk_val);
    d_wk2     = wake_lookup(bus.reg2[ROB_W-1:0], bus.wk_valid, bus.wk_idx, bus.wk_val);
    d_r1ok    = bus.rs1_ready | d_wk1.hit;
    d_v1      = (!bus.rs1_ready && d_wk1.hit) ? d_wk1.val : bus.reg1;
    d_r2ok    = d_use_imm | bus.rs2_ready | d_wk2.hit;
    d_v2      = d_use_imm ? bus.imm :
                (!bus.rs2_ready && d_wk2.hit) ? d_wk2.val : bus.reg2;
  end

  // A new entry's row records every surviving entry as older; its column is cleared elsewhere.
  always_ff @(posedge clk) begin
    if (rst || (bus.rdy && bus.jp_wrong)) begin
      valid       <= '0;
      r1ok        <= '0;
      r2ok        <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      ari_valid_q <= 1'b0;
      ari_idx_q   <= '0;
      ari_val_q   <= '0;
      cmp_valid_q <= 1'b0;
      cmp_idx_q   <= '0;
      cmp_val_q   <= '0;
    end else if (bus.rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue[i]) begin
          valid[i] <= 1'b0;
        end else if (valid[i]) begin
          if (!r1ok[i] && wk1[i].hit) begin
            r1ok[i] <= 1'b1;
            v1[i]   <= wk1[i].val;
          end
          if (!r2ok[i] && wk2[i].hit) begin
            r2ok[i] <= 1'b1;
            v2[i]   <= wk2[i].val;
          end
        end
        if (do_disp && alloc == IDX_W'(i)) begin
          valid[i] <= 1'b1;
          op[i]    <= bus.insty;
          rob[i]   <= bus.rob_idx;
          r1ok[i]  <= d_r1ok;
          v1[i]    <= d_v1;
          r2ok[i]  <= d_r2ok;
          v2[i]    <= d_v2;
          older[i] <= valid & ~issue;
        end else if (do_disp) begin
          older[i][alloc] <= 1'b0;
        end
      end
      ari_valid_q <= any_a;
      ari_idx_q   <= any_a ? a_rob : '0;
      ari_val_q   <= any_a ? alu(a_op, a_v1, a_v2) : '0;
      cmp_valid_q <= any_c;
      cmp_idx_q   <= any_c ? c_rob : '0;
      cmp_val_q   <= any_c ? alu(c_op, c_v1, c_v2) : '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.occupancy = OCC_W'($countones(valid));
  assign bus.ari_valid = ari_valid_q;
  assign bus.ari_idx   = ari_idx_q;
  assign bus.ari_val   = ari_val_q;
  assign bus.cmp_valid = cmp_valid_q;
  assign bus.cmp_idx   = cmp_idx_q;
  assign bus.cmp_val   = cmp_val_q;

`ifdef RS_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  // Counters survive mispredict flushes; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else if (bus.rdy) begin
      if (!bus.jp_wrong) perf_issue_q <= perf_issue_q + 32'(any_a) + 32'(any_c);
      if (bus.in_valid && !in_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_issue = perf_issue_q;
  assign bus.perf_stall = perf_stall_q;
`else
  assign bus.perf_issue = '0;
  assign bus.perf_stall = '0;
`endif
endmodule

// File: tb/tb_rs_age_dual_issue.sv
// Directed self-checking bench for rs_age_dual_issue: latency, wakeup, age order, dual issue,
// ALU corner cases, full back-pressure and mispredict flush, with expected values written by hand.
module tb_rs_age_dual_issue;
  localparam logic [5:0] OP_ADDI = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_XORI = 6'd4;
  localparam logic [5:0] OP_SLL  = 6'd11, OP_SRLI = 6'd12, OP_SRA  = 6'd15, OP_SLT  = 6'd17;
  localparam logic [5:0] OP_SLTU = 6'd19, OP_BEQ  = 6'd32, OP_BLT  = 6'd34, OP_BGEU = 6'd37;
  localparam logic [5:0] OP_JALR = 6'd38, OP_UNK_A = 6'd3, OP_UNK_C = 6'd50;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_issues;

  rs_age_dual_issue_if #(.DEPTH(16), .XLEN(32), .ROB_W(4), .INS_W(6), .NWAKE(2)) bus ();

  rs_age_dual_issue #(.DEPTH(16), .XLEN(32), .ROB_W(4), .INS_W(6), .NWAKE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkLane(input string tag, input bit cmp, input logic [3:0] idx, input logic [31:0] val);
    if (cmp) begin
      checkOutput({tag, "_cmp_valid"}, 64'(bus.cmp_valid), 64'd1);
      checkOutput({tag, "_cmp_idx"},   64'(bus.cmp_idx),   64'(idx));
      checkOutput({tag, "_cmp_val"},   64'(bus.cmp_val),   64'(val));
    end else begin
      checkOutput({tag, "_ari_valid"}, 64'(bus.ari_valid), 64'd1);
      checkOutput({tag, "_ari_idx"},   64'(bus.ari_idx),   64'(idx));
      checkOutput({tag, "_ari_val"},   64'(bus.ari_val),   64'(val));
    end
    exp_issues++;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic r1ok, input logic [31:0] r1,
                               input logic r2ok, input logic [31:0] r2, input logic [31:0] imm_v,
                               input logic [3:0] rob);
    bus.in_valid  = 1'b1;
    bus.insty     = op;
    bus.rs1_ready = r1ok;
    bus.reg1      = r1;
    bus.rs2_ready = r2ok;
    bus.reg2      = r2;
    bus.imm       = imm_v;
    bus.rob_idx   = rob;
  endtask

  task automatic setWake(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                         input logic [3:0] t1, input logic [31:0] d1);
    bus.wk_valid = v;
    bus.wk_idx   = {t1, t0};
    bus.wk_val   = {d1, d0};
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.jp_wrong = 1'b0;
    setWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic runSingle(input string tag, input logic [5:0] op, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] imm_v, input logic [3:0] rob,
                           input bit cmp, input logic [31:0] expv);
    applyStimulus(op, 1'b1, r1, 1'b1, r2, imm_v, rob);
    tick();
    idle();
    tick();
    checkLane(tag, cmp, rob, expv);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_issues = 0;
    rst        = 1'b1;
    bus.rdy    = 1'b1;
    applyStimulus(6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    idle();
    tick();
    tick();
    checkOutput("reset_occ",       64'(bus.occupancy), 64'd0);
    checkOutput("reset_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("reset_ari_valid", 64'(bus.ari_valid), 64'd0);
    checkOutput("reset_cmp_valid", 64'(bus.cmp_valid), 64'd0);
    rst = 1'b0;

    $display("[TB] ADDI latency and rdy hold");
    applyStimulus(OP_ADDI, 1'b1, 32'd5, 1'b1, 32'd99, 32'd7, 4'd3);
    tick();
    idle();
    checkOutput("addi_occ_after_dispatch", 64'(bus.occupancy), 64'd1);
    checkOutput("addi_not_yet_valid",      64'(bus.ari_valid), 64'd0);
    tick();
    checkLane("addi", 1'b0, 4'd3, 32'd12);
    checkOutput("addi_occ_after_issue", 64'(bus.occupancy), 64'd0);
    bus.rdy = 1'b0;
    applyStimulus(OP_ADDI, 1'b1, 32'd1, 1'b1, 32'd0, 32'd1, 4'd4);
    tick();
    checkOutput("hold_ari_valid", 64'(bus.ari_valid), 64'd1);
    checkOutput("hold_ari_val",   64'(bus.ari_val),   64'd12);
    checkOutput("hold_occ",       64'(bus.occupancy), 64'd0);
    bus.rdy = 1'b1;
    idle();
    tick();
    checkOutput("after_hold_ari_valid", 64'(bus.ari_valid), 64'd0);

    $display("[TB] wakeup of a waiting operand");
    applyStimulus(OP_ADD, 1'b0, 32'd2, 1'b1, 32'd1, 32'd0, 4'd5);
    tick();
    idle();
    tick();
    checkOutput("wait_no_issue", 64'(bus.ari_valid), 64'd0);
    setWake(2'b10, 4'd0, 32'd0, 4'd2, 32'h10);
    tick();
    idle();
    checkLane("wake_port1", 1'b0, 4'd5, 32'h11);
    applyStimulus(OP_ADD, 1'b0, 32'd7, 1'b1, 32'd1, 32'd0, 4'd6);
    setWake(2'b11, 4'd7, 32'h100, 4'd7, 32'h200);
    tick();
    idle();
    tick();
    checkLane("dispatch_wake_low_port", 1'b0, 4'd6, 32'h101);

    $display("[TB] age order differs from slot order");
    applyStimulus(OP_ADD, 1'b0, 32'd9, 1'b1, 32'd1, 32'd0, 4'd1);
    tick();
    applyStimulus(OP_ADD, 1'b0, 32'd8, 1'b1, 32'd2, 32'd0, 4'd2);
    tick();
    applyStimulus(OP_ADD, 1'b0, 32'd9, 1'b1, 32'd3, 32'd0, 4'd3);
    tick();
    idle();
    checkOutput("age_occ3", 64'(bus.occupancy), 64'd3);
    setWake(2'b01, 4'd8, 32'h20, 4'd0, 32'd0);
    tick();
    idle();
    checkLane("age_b", 1'b0, 4'd2, 32'h22);
    applyStimulus(OP_ADD, 1'b0, 32'd9, 1'b1, 32'd4, 32'd0, 4'd4);
    tick();
    idle();
    checkOutput("age_occ_refill", 64'(bus.occupancy), 64'd3);
    setWake(2'b01, 4'd9, 32'h100, 4'd0, 32'd0);
    tick();
    idle();
    checkLane("age_first", 1'b0, 4'd1, 32'h101);
    tick();
    checkLane("age_second", 1'b0, 4'd3, 32'h103);
    tick();
    checkLane("age_third", 1'b0, 4'd4, 32'h104);
    tick();
    checkOutput("age_drained_valid", 64'(bus.ari_valid), 64'd0);
    checkOutput("age_drained_occ",   64'(bus.occupancy), 64'd0);

    $display("[TB] dual issue with same-cycle dispatch");
    applyStimulus(OP_BLT, 1'b0, 32'd11, 1'b1, 32'd1, 32'd0, 4'd7);
    tick();
    applyStimulus(OP_SUB, 1'b0, 32'd12, 1'b1, 32'd4, 32'd0, 4'd8);
    tick();
    idle();
    checkOutput("dual_occ2", 64'(bus.occupancy), 64'd2);
    setWake(2'b11, 4'd11, 32'hFFFF_FFFF, 4'd12, 32'd9);
    applyStimulus(OP_ADD, 1'b0, 32'd15, 1'b1, 32'd0, 32'd0, 4'd0);
    tick();
    idle();
    checkLane("dual_blt", 1'b1, 4'd7, 32'd1);
    checkLane("dual_sub", 1'b0, 4'd8, 32'd5);
    checkOutput("dual_occ_after", 64'(bus.occupancy), 64'd1);
    setWake(2'b10, 4'd0, 32'd0, 4'd15, 32'h33);
    tick();
    idle();
    checkLane("leftover", 1'b0, 4'd0, 32'h33);

    $display("[TB] ALU corner cases");
    runSingle("sra",   OP_SRA,   32'h8000_0000, 32'd4,         32'd0,    4'd9,  1'b0, 32'hF800_0000);
    runSingle("srli",  OP_SRLI,  32'h8000_0000, 32'hDEAD,      32'd31,   4'd10, 1'b0, 32'd1);
    runSingle("slt",   OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd0,    4'd11, 1'b0, 32'd1);
    runSingle("sltu",  OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,    4'd12, 1'b0, 32'd0);
    runSingle("xori",  OP_XORI,  32'hFF,        32'd0,         32'h0F,   4'd13, 1'b0, 32'hF0);
    runSingle("sll5",  OP_SLL,   32'd1,         32'h21,        32'd0,    4'd3,  1'b0, 32'd2);
    runSingle("bgeu",  OP_BGEU,  32'd1,         32'hFFFF_FFFF, 32'd0,    4'd14, 1'b1, 32'd0);
    runSingle("jalr",  OP_JALR,  32'h1001,      32'h5555,      32'h10,   4'd15, 1'b1, 32'h1010);
    runSingle("unk_a", OP_UNK_A, 32'd5,         32'd6,         32'd0,    4'd1,  1'b0, 32'd0);
    runSingle("unk_c", OP_UNK_C, 32'd5,         32'd6,         32'd0,    4'd2,  1'b1, 32'd0);

    $display("[TB] fill to full and hold dispatch");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(OP_ADD, 1'b0, 32'd13, 1'b1, 32'(i), 32'd0, 4'(i));
      tick();
    end
    checkOutput("full_in_ready", 64'(bus.in_ready),  64'd0);
    checkOutput("full_occ",      64'(bus.occupancy), 64'd16);
    tick();
    tick();
    tick();
    checkOutput("full_held_occ",      64'(bus.occupancy), 64'd16);
    checkOutput("full_held_in_ready", 64'(bus.in_ready),  64'd0);
`ifdef RS_PERF_EN
    checkOutput("perf_stall", 64'(bus.perf_stall), 64'd3);
`else
    checkOutput("perf_stall_off", 64'(bus.perf_stall), 64'd0);
`endif
    bus.jp_wrong = 1'b1;
    tick();
    idle();
    checkOutput("flush_full_occ",      64'(bus.occupancy), 64'd0);
    checkOutput("flush_full_in_ready", 64'(bus.in_ready),  64'd1);

    $display("[TB] mispredict flush with a pending issue");
    applyStimulus(OP_ADD, 1'b0, 32'd14, 1'b1, 32'd0, 32'd0, 4'd1);
    tick();
    applyStimulus(OP_BEQ, 1'b0, 32'd14, 1'b1, 32'd0, 32'd0, 4'd2);
    tick();
    applyStimulus(OP_ADD, 1'b0, 32'd14, 1'b1, 32'd0, 32'd0, 4'd3);
    tick();
    applyStimulus(OP_ADD, 1'b0, 32'd14, 1'b1, 32'd0, 32'd0, 4'd4);
    tick();
    applyStimulus(OP_ADDI, 1'b1, 32'd100, 1'b1, 32'd0, 32'd1, 4'd9);
    tick();
    checkOutput("flush_pre_occ", 64'(bus.occupancy), 64'd5);
    applyStimulus(OP_ADDI, 1'b1, 32'd1, 1'b1, 32'd0, 32'd1, 4'd10);
    setWake(2'b01, 4'd14, 32'd0, 4'd0, 32'd0);
    bus.jp_wrong = 1'b1;
    tick();
    idle();
    checkOutput("flush_occ",       64'(bus.occupancy), 64'd0);
    checkOutput("flush_ari_valid", 64'(bus.ari_valid), 64'd0);
    checkOutput("flush_ari_val",   64'(bus.ari_val),   64'd0);
    checkOutput("flush_cmp_valid", 64'(bus.cmp_valid), 64'd0);
    tick();
    checkOutput("post_flush_ari_valid", 64'(bus.ari_valid), 64'd0);
    checkOutput("post_flush_cmp_valid", 64'(bus.cmp_valid), 64'd0);
    checkOutput("post_flush_occ",       64'(bus.occupancy), 64'd0);

`ifdef RS_PERF_EN
    checkOutput("perf_issue", 64'(bus.perf_issue), 64'(exp_issues));
`else
    checkOutput("perf_issue_off", 64'(bus.perf_issue), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
